// File: rtl/tlu_record_packer.sv
// tlu_record_packer: packs 8x16-bit TLU trigger records into 4x32-bit words.
// Optional TRIG_ID continuity counter: define TLU_PACKER_ID_CHECK_EN.
module tlu_record_packer #(
   parameter int DEPTH     = 16,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 BUS_CLK,
   input  logic                 BUS_RST_N,
   input  logic                 ENABLE,
   input  logic                 FIFO_EMPTY,
   input  logic [15:0]          FIFO_DATA,
   output logic                 FIFO_READ,
   input  logic                 OUT_READ,
   output logic                 OUT_EMPTY,
   output logic [31:0]          OUT_DATA,
   output logic                 OUT_SOF,
   output logic                 BUSY,
   output logic [CNT_WIDTH-1:0] RECORD_CNT,
   output logic [15:0]          ID_ERR_CNT
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [2:0]    word_idx;
   logic [2:0]    word_idx_nxt;
   logic [15:0]   lo;
   logic [AW:0]   occ;
   logic [AW:0]   free;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [32:0]   mem [DEPTH];
   logic          admit;
   logic          push;
   logic          pop;
   logic          last;

   // Admission needs room for a whole record, so overflow cannot happen.
   assign free  = (AW+1)'(DEPTH) - occ;
   assign admit = ENABLE && !FIFO_EMPTY && (free >= (AW+1)'(4));

   always_comb begin
      state_nxt    = state;
      word_idx_nxt = word_idx;
      FIFO_READ    = 1'b0;
      unique case (state)
         IDLE: begin
            if (admit) begin
               FIFO_READ    = 1'b1;
               state_nxt    = STREAM;
               word_idx_nxt = 3'd1;
            end
         end
         STREAM: begin
            FIFO_READ    = 1'b1;
            word_idx_nxt = word_idx + 3'd1;
            if (word_idx == 3'd7) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt    = IDLE;
            word_idx_nxt = 3'd0;
         end
      endcase
   end

   assign push      = FIFO_READ && word_idx[0];
   assign last      = push && (word_idx == 3'd7);
   assign OUT_EMPTY = (occ == '0);
   assign pop       = OUT_READ && !OUT_EMPTY;
   assign BUSY      = (state == STREAM);
   assign OUT_DATA  = mem[rd_ptr][31:0];
   assign OUT_SOF   = !OUT_EMPTY && mem[rd_ptr][32];

   always_ff @(posedge BUS_CLK) begin
      if (!BUS_RST_N) begin
         state      <= IDLE;
         word_idx   <= 3'd0;
         lo         <= 16'h0;
         occ        <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         RECORD_CNT <= '0;
      end else begin
         state    <= state_nxt;
         word_idx <= word_idx_nxt;
         if (FIFO_READ && !word_idx[0]) begin
            lo <= FIFO_DATA;
         end
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            occ <= occ + (AW+1)'(1);
         end else if (pop && !push) begin
            occ <= occ - (AW+1)'(1);
         end
         if (last) begin
            RECORD_CNT <= RECORD_CNT + CNT_WIDTH'(1);
         end
      end
   end

   // Storage needs no reset: the pointers define what is valid.
   always_ff @(posedge BUS_CLK) begin
      if (push) begin
         mem[wr_ptr] <= {(word_idx == 3'd1), FIFO_DATA, lo};
      end
   end

`ifdef TLU_PACKER_ID_CHECK_EN
   logic [31:0] trig_id;
   logic [31:0] last_id;
   logic        have_id;
   logic [15:0] err_cnt;

   assign trig_id = {FIFO_DATA, lo};

   always_ff @(posedge BUS_CLK) begin
      if (!BUS_RST_N) begin
         last_id <= 32'h0;
         have_id <= 1'b0;
         err_cnt <= 16'h0;
      end else if (last) begin
         last_id <= trig_id;
         have_id <= 1'b1;
         if (have_id && (trig_id != last_id + 32'd1)
             && (err_cnt != 16'hffff)) begin
            err_cnt <= err_cnt + 16'd1;
         end
      end
   end

   assign ID_ERR_CNT = err_cnt;
`else
   assign ID_ERR_CNT = 16'h0;
`endif

endmodule

// File: tb/tb_tlu_record_packer.sv
// tb_tlu_record_packer: queue-based reference model of tlu_record_packer
// with directed scenarios and a randomized traffic phase.
module tb_tlu_record_packer;

   localparam int DEPTH = 16;
   localparam int CW    = 32;

   logic          BUS_CLK    = 1'b0;
   logic          BUS_RST_N  = 1'b0;
   logic          ENABLE     = 1'b0;
   logic          FIFO_EMPTY = 1'b1;
   logic [15:0]   FIFO_DATA  = 16'h0;
   logic          OUT_READ   = 1'b0;
   logic          FIFO_READ;
   logic          OUT_EMPTY;
   logic [31:0]   OUT_DATA;
   logic          OUT_SOF;
   logic          BUSY;
   logic [CW-1:0] RECORD_CNT;
   logic [15:0]   ID_ERR_CNT;

   tlu_record_packer #(
      .DEPTH     (DEPTH),
      .CNT_WIDTH (CW)
   ) dut (
      .BUS_CLK    (BUS_CLK),
      .BUS_RST_N  (BUS_RST_N),
      .ENABLE     (ENABLE),
      .FIFO_EMPTY (FIFO_EMPTY),
      .FIFO_DATA  (FIFO_DATA),
      .FIFO_READ  (FIFO_READ),
      .OUT_READ   (OUT_READ),
      .OUT_EMPTY  (OUT_EMPTY),
      .OUT_DATA   (OUT_DATA),
      .OUT_SOF    (OUT_SOF),
      .BUSY       (BUSY),
      .RECORD_CNT (RECORD_CNT),
      .ID_ERR_CNT (ID_ERR_CNT)
   );

   always #5 BUS_CLK = ~BUS_CLK;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Upstream FIFO emulation (popped on the DUT strobe) and the model's copy
   logic [15:0] up_q[$];
   logic [15:0] mq[$];
   bit          pop_req = 0;

   // Reference model state
   bit          m_in_rec;
   int          m_widx;
   logic [15:0] m_lo;
   logic [32:0] m_out[$];
   logic [CW-1:0] m_cnt;
   logic [15:0] m_err;
   bit          m_have;
   logic [31:0] m_last;
   bit          rst_q = 0;
   int          rd_count = 0;
   int          run = 0;
   int          max_run = 0;
   logic [31:0] next_id = 32'h0;

   task automatic model_reset();
      m_in_rec = 0;
      m_widx   = 0;
      m_lo     = 16'h0;
      m_out.delete();
      mq.delete();
      m_cnt    = '0;
      m_err    = 16'h0;
      m_have   = 0;
      m_last   = 32'h0;
   endtask

   always @(posedge BUS_CLK) rst_q <= !BUS_RST_N;

   always @(negedge BUS_CLK) begin
      int occ;
      bit adm;
      bit exp_rd;
      logic [15:0] w;
      logic [31:0] id;
      if (!BUS_RST_N) begin
         if (rst_q) begin
            chk("rst_fifo_read", FIFO_READ, 0);
            chk("rst_out_empty", OUT_EMPTY, 1);
            chk("rst_out_sof", OUT_SOF, 0);
            chk("rst_busy", BUSY, 0);
            chk("rst_record_cnt", RECORD_CNT, 0);
            chk("rst_id_err_cnt", ID_ERR_CNT, 0);
         end
         model_reset();
         pop_req = 0;
         run = 0;
      end else begin
         occ    = m_out.size();
         adm    = !m_in_rec && ENABLE && !FIFO_EMPTY && (DEPTH - occ >= 4);
         exp_rd = m_in_rec || adm;
         chk("fifo_read", FIFO_READ, exp_rd);
         chk("busy", BUSY, m_in_rec);
         chk("out_empty", OUT_EMPTY, occ == 0);
         if (occ > 0) begin
            chk("out_data", OUT_DATA, m_out[0][31:0]);
            chk("out_sof", OUT_SOF, m_out[0][32]);
         end
         chk("record_cnt", RECORD_CNT, m_cnt);
         chk("id_err_cnt", ID_ERR_CNT, m_err);
         chk("occ_bound", dut.occ <= DEPTH, 1);
         pop_req = FIFO_READ;
         if (FIFO_READ) begin
            rd_count++;
            run++;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
         if (OUT_READ && occ > 0) void'(m_out.pop_front());
         if (exp_rd) begin
            if (mq.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL model_underflow: read with no upstream data at %0t",
                        $time);
            end else begin
               w = mq.pop_front();
               if (m_widx % 2 == 0) begin
                  m_lo = w;
               end else begin
                  m_out.push_back({m_widx == 1, w, m_lo});
               end
               if (m_widx == 7) begin
                  m_cnt++;
                  id = {w, m_lo};
`ifdef TLU_PACKER_ID_CHECK_EN
                  if (m_have && id != m_last + 32'd1 && m_err != 16'hffff)
                     m_err++;
`endif
                  m_have = 1;
                  m_last = id;
               end
               m_widx   = (m_widx + 1) % 8;
               m_in_rec = (m_widx != 0);
            end
         end
      end
   end

   task automatic drive_up();
      FIFO_EMPTY = (up_q.size() == 0);
      FIFO_DATA  = (up_q.size() > 0) ? up_q[0] : 16'h0;
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge BUS_CLK);
         #1;
         if (pop_req && up_q.size() > 0) void'(up_q.pop_front());
         pop_req = 0;
         drive_up();
      end
   endtask

   task automatic add_rec(input logic [15:0] w[8]);
      for (int i = 0; i < 8; i++) begin
         up_q.push_back(w[i]);
         mq.push_back(w[i]);
      end
      drive_up();
   endtask

   task automatic add_id(input logic [31:0] id);
      logic [15:0] w[8];
      for (int i = 0; i < 6; i++) w[i] = 16'($urandom);
      w[6] = id[15:0];
      w[7] = id[31:16];
      add_rec(w);
      next_id = id + 32'd1;
   endtask

   task automatic do_reset();
      BUS_RST_N = 1'b0;
      up_q.delete();
      pop_req = 0;
      drive_up();
      cyc(2);
      BUS_RST_N = 1'b1;
   endtask

   logic [15:0] seq_w[8];
   logic [31:0] t1w[4];

   initial begin
      for (int i = 0; i < 8; i++) seq_w[i] = 16'(i + 1);
      t1w[0] = 32'h00020001;
      t1w[1] = 32'h00040003;
      t1w[2] = 32'h00060005;
      t1w[3] = 32'h00080007;

      do_reset();

      // Single record, literal packing
      ENABLE   = 1'b1;
      rd_count = 0;
      add_rec(seq_w);
      cyc(12);
      chk("t1_reads", rd_count, 8);
      chk("t1_cnt", RECORD_CNT, 1);
      for (int k = 0; k < 4; k++) begin
         chk("t1_word", OUT_DATA, t1w[k]);
         chk("t1_sof", OUT_SOF, k == 0);
         OUT_READ = 1'b1;
         cyc(1);
         OUT_READ = 1'b0;
      end
      chk("t1_empty", OUT_EMPTY, 1);
      next_id = 32'h00080008;

      // Buffer-full admission limit
      rd_count = 0;
      for (int r = 0; r < 5; r++) add_id(next_id);
      cyc(60);
      chk("t2_reads", rd_count, 32);
      chk("t2_stalled", FIFO_READ, 0);
      chk("t2_cnt", RECORD_CNT, 5);
      chk("t2_pending", FIFO_EMPTY, 0);
      OUT_READ = 1'b1;
      cyc(4);
      OUT_READ = 1'b0;
      chk("t2_readmit", FIFO_READ, 1);
      OUT_READ = 1'b1;
      cyc(60);
      chk("t2_drained", OUT_EMPTY, 1);
      chk("t2_cnt_end", RECORD_CNT, 6);

      // Back-to-back throughput
      rd_count = 0;
      max_run  = 0;
      add_id(next_id);
      add_id(next_id);
      cyc(30);
      chk("t3_run", max_run, 16);
      chk("t3_reads", rd_count, 16);
      chk("t3_cnt", RECORD_CNT, 8);

      // ENABLE dropped mid-record
      add_id(next_id);
      add_id(next_id);
      rd_count = 0;
      for (int i = 0; i < 20 && rd_count < 4; i++) cyc(1);
      chk("t4_started", rd_count >= 4, 1);
      ENABLE = 1'b0;
      cyc(20);
      chk("t4_reads", rd_count, 8);
      chk("t4_idle", BUSY, 0);
      chk("t4_no_read", FIFO_READ, 0);
      chk("t4_pending", FIFO_EMPTY, 0);
      ENABLE = 1'b1;
      cyc(25);
      chk("t4_reads_end", rd_count, 16);
      chk("t4_cnt", RECORD_CNT, 10);

      // Reset mid-record together with upstream
      add_id(next_id);
      rd_count = 0;
      for (int i = 0; i < 20 && rd_count < 3; i++) cyc(1);
      do_reset();
      chk("t5_cnt", RECORD_CNT, 0);
      chk("t5_empty", OUT_EMPTY, 1);
      chk("t5_busy", BUSY, 0);
      OUT_READ = 1'b0;
      add_rec(seq_w);
      cyc(12);
      chk("t5_w0", OUT_DATA, 32'h00020001);
      chk("t5_sof", OUT_SOF, 1);
      chk("t5_cnt_end", RECORD_CNT, 1);
      OUT_READ = 1'b1;
      cyc(6);

      // TRIG_ID continuity
      do_reset();
      add_id(32'd5);
      add_id(32'd6);
      add_id(32'd8);
      add_id(32'd9);
      cyc(50);
      chk("t6_cnt", RECORD_CNT, 4);
`ifdef TLU_PACKER_ID_CHECK_EN
      chk("t6_id_err", ID_ERR_CNT, 1);
`else
      chk("t6_id_err", ID_ERR_CNT, 0);
`endif

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         ENABLE   = ($urandom % 8) != 0;
         OUT_READ = ($urandom % 2) != 0;
         if (up_q.size() < 24 && ($urandom % 6) == 0) begin
            if (($urandom % 10) == 0) add_id($urandom);
            else add_id(next_id);
         end
         cyc(1);
      end
      ENABLE   = 1'b1;
      OUT_READ = 1'b1;
      for (int i = 0; i < 300 && !(up_q.size() == 0 && OUT_EMPTY && !BUSY); i++)
         cyc(1);
      chk("rand_up_drained", up_q.size(), 0);
      chk("rand_out_drained", OUT_EMPTY, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
